regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-ported integer register file with an integrated issue scoreboard. It replaces the single-write, two-read CPU register file for the dual-writeback pipeline. It provides NRP read ports with optional same-cycle write bypass, two prioritised write ports, and per-register busy tracking. Register 0 is hardwired to zero. The block sits between decode/issue (reads, busy checks, destination reservation) and the two writeback stages (ALU and load/MUL).

## Interface
- XLEN, 32: data width in bits, ≥ 8.
- NREG, 32: number of architectural registers; power of two, ≥ 4.
- NRP, 2: number of read ports, 1..4.
- BYPASS, 1: 1 = a same-cycle write is forwarded to the read ports; 0 = a write becomes visible next cycle.
- AW (derived, not overridable): $clog2(NREG).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- we0  in  1  write-port-0 enable (ALU writeback).
- wa0  in  AW  write-port-0 address.
- wd0  in  XLEN  write-port-0 data.
- we1  in  1  write-port-1 enable (load/MUL writeback); higher priority than port 0.
- wa1  in  AW  write-port-1 address.
- wd1  in  XLEN  write-port-1 data.
- ra  in  NRP*AW  read addresses; port i occupies bits [i*AW +: AW].
- rdata  out  NRP*XLEN  read data; port i occupies bits [i*XLEN +: XLEN].
- rbusy  out  NRP  1 = the register on read port i has a pending producer.
- iss_valid  in  1  reserve destination iss_rd this cycle.
- iss_rd  in  AW  destination register to reserve.
- iss_stall  out  1  combinational; 1 = iss_valid is high and iss_rd is already busy (WAW hazard). The reservation is dropped.
- flush  in  1  synchronous; clears every busy bit and leaves data intact.

## Operation
- Storage: rf[NREG] × XLEN and busy[NREG].
- Reset: all rf entries = 0, all busy = 0. Outputs follow combinationally: rdata = 0 for every port, rbusy = 0, iss_stall = 0 while iss_valid is low.
- Writes:
  - On the rising edge, if weN is high and waN ≠ 0, then rf[waN] ← wdN.
  - If both ports write the same address, port 1 wins.
  - Writes to address 0 are discarded.
- Reads (combinational), for each port i:
  - ra_i = 0 → rdata_i = 0.
  - Otherwise, if BYPASS = 1 and we1 is high with wa1 = ra_i → wd1.
  - Otherwise, if BYPASS = 1 and we0 is high with wa0 = ra_i → wd0.
  - Otherwise → rf[ra_i].
- Scoreboard, evaluated per edge in this priority order:
  1. flush: all busy ← 0. Any issue in the same cycle is ignored.
  2. Set: iss_valid && !iss_stall && iss_rd ≠ 0 → busy[iss_rd] ← 1.
  3. Clear: weN && waN ≠ 0 → busy[waN] ← 0, unless the same register is being set this cycle; in that case set wins and the new producer is tracked.
- rbusy_i:
  - rbusy_i = busy[ra_i] && ra_i ≠ 0.
  - When BYPASS = 1, rbusy_i is forced to 0 if a write to ra_i occurs this cycle (the value is being forwarded).
- iss_stall = iss_valid && iss_rd ≠ 0 && busy[iss_rd]. A write to iss_rd in the same cycle does not unstall the issue.
- Register 0 is never busy and never stalls.

## Timing
- Write-to-read latency:
  - BYPASS = 1: 0 cycles (same cycle).
  - BYPASS = 0: 1 cycle (visible after the edge).
- Issue to busy visible on rbusy: 1 cycle.
- Writeback to busy clear: 1 cycle, or 0 cycles on rbusy via the bypass when BYPASS = 1.
- iss_stall is purely combinational from iss_valid, iss_rd and busy. There is no registered output.
- Asynchronous reset mid-operation: state clears immediately, independent of clk. Writes or issues present during reset are lost. The first update occurs on the first rising edge after rst deasserts.
- flush together with a write: the data write still happens, and busy ends at 0.

## Test plan
- Reset, then read all 32 registers → rdata = 0 and rbusy = 0 everywhere. Write 0xDEADBEEF to register 0 → reads stay 0.
- we0 to r5 = 0x11 and we1 to r5 = 0x22 in the same cycle, with ra0 = 5:
  - BYPASS = 1: rdata0 = 0x22 that cycle.
  - Next cycle: rdata0 = 0x22.
  - BYPASS = 0: rdata0 shows the old value that cycle and 0x22 the next cycle.
- Issue r7, then next cycle read r7 → rbusy = 1. Issue r7 again → iss_stall = 1 and busy stays 1. we0 r7 = 0x55 → rbusy = 0 the same cycle (BYPASS = 1) with rdata = 0x55. Next cycle busy[7] = 0.
- Writeback r9 and issue r9 in the same cycle (r9 not busy) → busy[9] = 1 afterwards. rf[9] holds the written data.
- Issue r3, r4, r6 in consecutive cycles, then assert flush with we0 r4 = 0xAB → all busy bits = 0 and rf[4] = 0xAB.
- With NRP = 4, XLEN = 64, NREG = 64: random writes and reads on all ports, checked against a reference model. Assert rst mid-sequence → all outputs go to 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: multi-ported register file with two prioritised write ports, optional write bypass and issue scoreboard
// Ports: clk/rst (async active-high); we0/wa0/wd0 ALU writeback; we1/wa1/wd1 load/MUL writeback (wins ties);
// ra/rdata/rbusy NRP packed read ports; iss_valid/iss_rd/iss_stall destination reservation; flush clears busy bits.
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRP = 2,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we0,
  input  logic [AW-1:0]     wa0,
  input  logic [XLEN-1:0]   wd0,
  input  logic              we1,
  input  logic [AW-1:0]     wa1,
  input  logic [XLEN-1:0]   wd1,
  input  logic [NRP*AW-1:0] ra,
  output logic [NRP*XLEN-1:0] rdata,
  output logic [NRP-1:0]    rbusy,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  output logic              iss_stall,
  input  logic              flush
);
  logic [XLEN-1:0] rf [NREG];
  logic [NREG-1:0] busy, busy_nxt, set_m, clr_m;
  logic do_set;
  assign iss_stall = iss_valid && iss_rd != '0 && busy[iss_rd];
  assign do_set = iss_valid && !iss_stall && iss_rd != '0;
  // set is ORed after clearing so a same-cycle reservation tracks the new producer
  always_comb begin
    set_m = '0;
    clr_m = '0;
    set_m[iss_rd] = do_set;
    clr_m[wa0] = we0;
    clr_m[wa1] = clr_m[wa1] | we1;
    busy_nxt = flush ? '0 : (busy & ~clr_m) | set_m;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      busy <= '0;
    end else begin
      if (we0 && wa0 != '0) rf[wa0] <= wd0;
      if (we1 && wa1 != '0) rf[wa1] <= wd1;
      busy <= busy_nxt;
    end
  end
  for (genvar g = 0; g < NRP; g++) begin : g_rd
    logic [AW-1:0] a;
    logic h0, h1;
    assign a = ra[g*AW +: AW];
    assign h1 = BYPASS != 0 && we1 && wa1 == a;
    assign h0 = BYPASS != 0 && we0 && wa0 == a;
    assign rdata[g*XLEN +: XLEN] = a == '0 ? '0 : h1 ? wd1 : h0 ? wd0 : rf[a];
    // a forwarded write means the producer has completed this cycle
    assign rbusy[g] = a != '0 && busy[a] && !(h0 || h1);
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: table-driven, directed and randomized checks of regfile_mp against a behavioural model
module tb_regfile_mp;
  localparam int X = 64, AW = 6, NP = 4;
  logic clk = 0, rst = 1;
  logic we0 = 0, we1 = 0, iss_valid = 0, flush = 0;
  logic [AW-1:0] wa0 = '0, wa1 = '0, iss_rd = '0;
  logic [X-1:0] wd0 = '0, wd1 = '0;
  logic [NP*AW-1:0] ra = '0;
  logic [NP*X-1:0] rdata;
  logic [NP-1:0] rbusy;
  logic iss_stall;
  logic b_we0 = 0, b_we1 = 0, b_iv = 0, b_fl = 0;
  logic [4:0] b_wa0 = '0, b_wa1 = '0, b_ird = '0;
  logic [31:0] b_wd0 = '0, b_wd1 = '0;
  logic [9:0] b_ra = '0;
  logic [63:0] b_rdata;
  logic [1:0] b_rbusy;
  logic b_stall;
  logic [X-1:0] mrf [64];
  bit mbusy [64];
  int errors = 0, checks = 0;
  typedef struct {
    logic we0; logic [5:0] wa0; logic [63:0] wd0;
    logic we1; logic [5:0] wa1; logic [63:0] wd1;
    logic [5:0] ra0; logic iv; logic [5:0] ird; logic fl;
    logic [63:0] xd; logic xb; logic xs;
  } vec_t;
  vec_t tbl [21];

  regfile_mp #(.XLEN(64), .NREG(64), .NRP(4), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra(ra), .rdata(rdata), .rbusy(rbusy), .iss_valid(iss_valid), .iss_rd(iss_rd),
    .iss_stall(iss_stall), .flush(flush));
  regfile_mp #(.XLEN(32), .NREG(32), .NRP(2), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .we0(b_we0), .wa0(b_wa0), .wd0(b_wd0), .we1(b_we1), .wa1(b_wa1), .wd1(b_wd1),
    .ra(b_ra), .rdata(b_rdata), .rbusy(b_rbusy), .iss_valid(b_iv), .iss_rd(b_ird),
    .iss_stall(b_stall), .flush(b_fl));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  function automatic logic [X-1:0] exp_rd(logic [AW-1:0] a);
    if (a == 0) return '0;
    if (we1 && wa1 == a) return wd1;
    if (we0 && wa0 == a) return wd0;
    return mrf[a];
  endfunction

  function automatic logic exp_rb(logic [AW-1:0] a);
    if (a == 0 || (we1 && wa1 == a) || (we0 && wa0 == a)) return 1'b0;
    return mbusy[a];
  endfunction

  function automatic logic exp_stall();
    return iss_valid && iss_rd != 0 && mbusy[iss_rd];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      mrf[i] = '0;
      mbusy[i] = 0;
    end
  endtask

  task automatic check_all(string tag);
    for (int i = 0; i < NP; i++) begin
      chk($sformatf("%s rdata%0d r%0d", tag, i, ra[i*AW +: AW]), rdata[i*X +: X], exp_rd(ra[i*AW +: AW]));
      chk($sformatf("%s rbusy%0d r%0d", tag, i, ra[i*AW +: AW]), 64'(rbusy[i]), 64'(exp_rb(ra[i*AW +: AW])));
    end
    chk({tag, " iss_stall"}, 64'(iss_stall), 64'(exp_stall()));
  endtask

  // one clock: advance the model by the rules for the inputs held across the edge
  task automatic tick();
    bit st;
    st = exp_stall();
    @(posedge clk);
    if (we0 && wa0 != 0) mrf[wa0] = wd0;
    if (we1 && wa1 != 0) mrf[wa1] = wd1;
    if (flush) begin
      for (int i = 0; i < 64; i++) mbusy[i] = 0;
    end else begin
      if (we0 && wa0 != 0) mbusy[wa0] = 0;
      if (we1 && wa1 != 0) mbusy[wa1] = 0;
      if (iss_valid && !st && iss_rd != 0) mbusy[iss_rd] = 1;
    end
    #1;
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; iss_valid = 0; flush = 0; wa0 = '0; wa1 = '0; iss_rd = '0;
  endtask

  function automatic logic [AW-1:0] rnd_a();
    return ($urandom_range(0, 2) == 0) ? AW'($urandom_range(0, 63)) : AW'($urandom_range(0, 7));
  endfunction

  task automatic rand_cycles(int n);
    for (int k = 0; k < n; k++) begin
      we0 = 1'($urandom_range(0, 1)); wa0 = rnd_a(); wd0 = {$urandom, $urandom};
      we1 = 1'($urandom_range(0, 1)); wa1 = rnd_a(); wd1 = {$urandom, $urandom};
      ra = {rnd_a(), rnd_a(), rnd_a(), rnd_a()};
      iss_valid = 1'($urandom_range(0, 1)); iss_rd = rnd_a();
      flush = ($urandom_range(0, 19) == 0);
      #1 check_all($sformatf("rnd%0d", k));
      tick();
    end
  endtask

  function automatic vec_t mk(logic e0, logic [5:0] a0, logic [63:0] d0, logic e1, logic [5:0] a1,
                              logic [63:0] d1, logic [5:0] r, logic iv, logic [5:0] ird, logic fl,
                              logic [63:0] xd, logic xb, logic xs);
    vec_t v;
    v.we0 = e0; v.wa0 = a0; v.wd0 = d0; v.we1 = e1; v.wa1 = a1; v.wd1 = d1;
    v.ra0 = r; v.iv = iv; v.ird = ird; v.fl = fl; v.xd = xd; v.xb = xb; v.xs = xs;
    return v;
  endfunction

  initial begin
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 64'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 5, 64'h11, 1, 5, 64'h22, 5, 0, 0, 0, 64'h22, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 64'h22, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 7, 1, 7, 0, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 7, 1, 7, 0, 0, 1, 1);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 1, 0);
    tbl[8]  = mk(1, 7, 64'h55, 0, 0, 0, 7, 0, 0, 0, 64'h55, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 64'h55, 0, 0);
    tbl[10] = mk(1, 9, 64'h99, 0, 0, 0, 9, 1, 9, 0, 64'h99, 0, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 64'h99, 1, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 3, 1, 3, 0, 0, 0, 0);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 3, 1, 4, 0, 0, 1, 0);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 4, 1, 6, 0, 0, 1, 0);
    tbl[15] = mk(1, 4, 64'hAB, 0, 0, 0, 6, 0, 0, 1, 0, 1, 0);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 64'hAB, 0, 0);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 6, 0, 0, 0, 0, 0, 0);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 10, 1, 10, 1, 0, 0, 0);
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 10, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int b = 0; b < 64; b += 4) begin
      ra = {AW'(b + 3), AW'(b + 2), AW'(b + 1), AW'(b)};
      #1 check_all($sformatf("rst_read%0d", b));
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 21; i++) begin
      we0 = tbl[i].we0; wa0 = tbl[i].wa0; wd0 = tbl[i].wd0;
      we1 = tbl[i].we1; wa1 = tbl[i].wa1; wd1 = tbl[i].wd1;
      ra = {6'd9, 6'd4, 6'd3, tbl[i].ra0};
      iss_valid = tbl[i].iv; iss_rd = tbl[i].ird; flush = tbl[i].fl;
      #1;
      chk($sformatf("tbl%0d rdata0", i), rdata[63:0], tbl[i].xd);
      chk($sformatf("tbl%0d rbusy0", i), 64'(rbusy[0]), 64'(tbl[i].xb));
      chk($sformatf("tbl%0d iss_stall", i), 64'(iss_stall), 64'(tbl[i].xs));
      check_all($sformatf("tbl%0d", i));
      tick();
    end
    idle();
    b_we0 = 1; b_wa0 = 5; b_wd0 = 32'h33; b_ra = {5'd0, 5'd5};
    #1 chk("nb old value before first write", b_rdata[31:0], 64'h0);
    tick();
    b_wd0 = 32'h11; b_we1 = 1; b_wa1 = 5; b_wd1 = 32'h22;
    #1 chk("nb dual write same cycle", b_rdata[31:0], 64'h33);
    chk("nb port1 r0", b_rdata[63:32], 64'h0);
    tick();
    b_we0 = 0; b_we1 = 0;
    #1 chk("nb dual write next cycle", b_rdata[31:0], 64'h22);
    b_iv = 1; b_ird = 7; b_ra = {5'd0, 5'd7};
    chk("nb first issue stall", 64'(b_stall), 64'h0);
    tick();
    #1 chk("nb busy after issue", 64'(b_rbusy[0]), 64'h1);
    chk("nb reissue stall", 64'(b_stall), 64'h1);
    tick();
    b_iv = 0; b_we0 = 1; b_wa0 = 7; b_wd0 = 32'h55;
    #1 chk("nb busy during write", 64'(b_rbusy[0]), 64'h1);
    chk("nb data during write", b_rdata[31:0], 64'h0);
    tick();
    b_we0 = 0;
    #1 chk("nb busy after write", 64'(b_rbusy[0]), 64'h0);
    chk("nb data after write", b_rdata[31:0], 64'h55);
    rand_cycles(150);
    idle();
    ra = {6'd4, 6'd3, 6'd2, 6'd1};
    #1 check_all("pre_rst");
    #1 rst = 1;
    #1;
    for (int i = 0; i < NP; i++) begin
      chk($sformatf("async rst rdata%0d", i), rdata[i*X +: X], 64'h0);
      chk($sformatf("async rst rbusy%0d", i), 64'(rbusy[i]), 64'h0);
    end
    chk("async rst iss_stall", 64'(iss_stall), 64'h0);
    we0 = 1; wa0 = 5; wd0 = 64'hCAFE; iss_valid = 1; iss_rd = 5;
    @(posedge clk);
    #1 rst = 0;
    idle();
    model_reset();
    ra = {6'd4, 6'd3, 6'd2, 6'd5};
    #1 chk("write during rst lost", rdata[63:0], 64'h0);
    chk("issue during rst lost", 64'(rbusy[0]), 64'h0);
    check_all("post_rst");
    rand_cycles(150);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
